dual_core_mem_arb: RTL
======================

DUAL_CORE_MEM_ARB -- requirements
Module: dual_core_mem_arb

Interface
REQ-001 Parameter: ADDR_W, 8, memory word address width.
REQ-002 Parameter: WDATA_W, 64, write data width.
REQ-003 Parameter: RDATA_W, 16, read data width.
REQ-004 clk  input  1  single clock; all state on rising edge.
REQ-005 rst_n  input  1  reset; synchronous, active-low.
REQ-006 c0_req / c1_req  input  1  core request; held until grant.
REQ-007 c0_we / c1_we  input  1  1 = write, 0 = read.
REQ-008 c0_addr / c1_addr  input  ADDR_W  word address.
REQ-009 c0_wdata / c1_wdata  input  WDATA_W  write data.
REQ-010 c0_gnt / c1_gnt  output  1  one-cycle pulse; request accepted.
REQ-011 c0_rvalid / c1_rvalid  output  1  one-cycle pulse; response valid.
REQ-012 c0_rdata / c1_rdata  output  RDATA_W  response data; valid while rvalid high.
REQ-013 mem_wd  output  1  write strobe to data memory.
REQ-014 mem_addr  output  ADDR_W  memory address.
REQ-015 mem_din  output  WDATA_W  memory write data.
REQ-016 mem_dout  input  RDATA_W  registered memory output; valid one cycle after the access edge.

Function
REQ-017 FSM states IDLE, ISSUE, WAIT; IDLE->ISSUE when any req sampled high; ISSUE->WAIT unconditionally; WAIT->IDLE unconditionally.
REQ-018 In IDLE with requests: arbiter latches winner's we/addr/wdata and owner id into registers.
REQ-019 Both requesting: round-robin; winner is the core not granted last; last-grant pointer reset value = core1, so core0 wins first contention after reset.
REQ-020 Single requester always wins regardless of pointer; pointer updates to the winner.
REQ-021 cN_gnt high exactly during the ISSUE cycle for the owner; never both high.
REQ-022 mem_wd = latched we during ISSUE only; 0 in IDLE and WAIT.
REQ-023 mem_addr/mem_din driven from latched registers; hold value outside ISSUE.
REQ-024 WAIT: mem_dout captured into owner's cN_rdata; owner's cN_rvalid high during following IDLE cycle; other core's rvalid and rdata unchanged.
REQ-025 Writes also produce rvalid; rdata = mem_dout (memory echoes wdata[15:0]).
REQ-026 Latency: req sampled at edge E -> gnt in cycle E+1 -> rvalid in cycle E+3; peak throughput one access per 3 cycles.
REQ-027 IDLE cycle carrying rvalid SHALL also accept a new request (back-to-back, no bubble).
REQ-028 req deasserted before gnt is dropped silently; req/we/addr/wdata changes after acceptance have no effect.
REQ-029 Width rules: no truncation/extension inside block; mem_dout passes bit-exact.

Reset
REQ-030 On rst_n=0 at clock edge: state=IDLE, gnt=0, rvalid=0, rdata=0, mem_wd=0, mem_addr=0, mem_din=0, pointer=core1.
REQ-031 Reset mid-transaction aborts it: no rvalid issued; write in ISSUE cycle with simultaneous reset SHALL not assert mem_wd.

Structure
REQ-032 Shared package holds FSM state enum (IDLE, ISSUE, WAIT), owner-id type, and ADDR_W/WDATA_W/RDATA_W defaults.
REQ-033 One sub-module rr_arb2: 2-requester round-robin grant with pointer; FSM and datapath stay in top.

Verification
REQ-034 Reset, core0 read addr 0x05, mem holds 0x1234 -> c0_gnt at cycle 1, c0_rvalid at cycle 3 with c0_rdata=0x1234.
REQ-035 Core1 write addr 0x10 data 0x0000_0000_0000_ABCD -> mem_wd=1 only in ISSUE cycle, c1_rvalid with 0xABCD; subsequent core0 read 0x10 returns 0xABCD.
REQ-036 Both req continuously after reset -> grants alternate c0,c1,c0,c1 every 3 cycles; never simultaneous.
REQ-037 Core0 req held continuously, back-to-back reads 0x01,0x02 -> second gnt in same cycle as first rvalid+1, no idle bubble.
REQ-038 rst_n low during WAIT of core0 read -> no c0_rvalid, all outputs zero next cycle, next contention granted to core0.

Source files
------------

// File: rtl/dual_core_mem_arb_pkg.sv
// Shared types and width defaults for the dual-core memory arbiter.
// Included by the top and by the round-robin grant sub-module.
package dual_core_mem_arb_pkg;

    localparam int unsigned DefAddrW  = 8;
    localparam int unsigned DefWdataW = 64;
    localparam int unsigned DefRdataW = 16;

    typedef enum logic [1:0] {
        StIdle,
        StIssue,
        StWait
    } state_e;

    typedef enum logic {
        OwnerC0 = 1'b0,
        OwnerC1 = 1'b1
    } owner_e;

endpackage

// File: rtl/dual_core_mem_arb_rr.sv
// Two-requester round-robin grant. On contention, the core that was not granted
// last wins. The last-grant pointer resets to core1, so core0 wins the first contention.
module rr_arb2
    import dual_core_mem_arb_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    input  logic req0,
    input  logic req1,
    input  logic advance,
    output logic winner
);

    owner_e last_q;
    owner_e win;

    always_comb begin
        win = OwnerC0;
        if (req0 && req1) begin
            if (last_q == OwnerC0) begin
                win = OwnerC1;
            end else begin
                win = OwnerC0;
            end
        end else if (req1) begin
            win = OwnerC1;
        end
    end

    assign winner = win;

    // A lone requester also moves the pointer, so fairness tracks actual grants.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            last_q <= OwnerC1;
        end else if (advance) begin
            last_q <= win;
        end
    end

endmodule

// File: rtl/dual_core_mem_arb.sv
// Arbitrates two cores onto one registered data memory with an IDLE/ISSUE/WAIT sequence.
// This gives one access every three cycles, and a new request is accepted in the IDLE cycle that carries rvalid.
module dual_core_mem_arb
    import dual_core_mem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W  = DefAddrW,
    parameter int unsigned WDATA_W = DefWdataW,
    parameter int unsigned RDATA_W = DefRdataW
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               c0_req,
    input  logic               c0_we,
    input  logic [ADDR_W-1:0]  c0_addr,
    input  logic [WDATA_W-1:0] c0_wdata,
    input  logic               c1_req,
    input  logic               c1_we,
    input  logic [ADDR_W-1:0]  c1_addr,
    input  logic [WDATA_W-1:0] c1_wdata,
    output logic               c0_gnt,
    output logic               c1_gnt,
    output logic               c0_rvalid,
    output logic               c1_rvalid,
    output logic [RDATA_W-1:0] c0_rdata,
    output logic [RDATA_W-1:0] c1_rdata,
    output logic               mem_wd,
    output logic [ADDR_W-1:0]  mem_addr,
    output logic [WDATA_W-1:0] mem_din,
    input  logic [RDATA_W-1:0] mem_dout
);

    state_e state_q, state_d;
    owner_e owner_q;
    logic   we_q;
    logic   [ADDR_W-1:0]  addr_q;
    logic   [WDATA_W-1:0] wdata_q;
    logic   rvalid0_q, rvalid1_q;
    logic   [RDATA_W-1:0] rdata0_q, rdata1_q;
    logic   accept;
    logic   win_id;
    logic   issue_live;
    logic   wait_c0, wait_c1;

    assign accept  = (state_q == StIdle) && (c0_req || c1_req);
    assign wait_c0 = (state_q == StWait) && (owner_q == OwnerC0);
    assign wait_c1 = (state_q == StWait) && (owner_q == OwnerC1);

    rr_arb2 u_rr_arb2 (
        .clk     (clk),
        .rst_n   (rst_n),
        .req0    (c0_req),
        .req1    (c1_req),
        .advance (accept),
        .winner  (win_id)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (c0_req || c1_req) state_d = StIssue;
            StIssue: state_d = StWait;
            StWait:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            owner_q   <= OwnerC0;
            we_q      <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            rvalid0_q <= 1'b0;
            rvalid1_q <= 1'b0;
            rdata0_q  <= '0;
            rdata1_q  <= '0;
        end else begin
            if (accept) begin
                owner_q <= owner_e'(win_id);
                if (win_id) begin
                    we_q    <= c1_we;
                    addr_q  <= c1_addr;
                    wdata_q <= c1_wdata;
                end else begin
                    we_q    <= c0_we;
                    addr_q  <= c0_addr;
                    wdata_q <= c0_wdata;
                end
            end
            rvalid0_q <= wait_c0;
            rvalid1_q <= wait_c1;
            if (wait_c0) rdata0_q <= mem_dout;
            if (wait_c1) rdata1_q <= mem_dout;
        end
    end

    // Gated by rst_n so a reset landing on the ISSUE cycle never commits a write.
    assign issue_live = rst_n && (state_q == StIssue);

    always_comb begin
        c0_gnt    = issue_live && (owner_q == OwnerC0);
        c1_gnt    = issue_live && (owner_q == OwnerC1);
        mem_wd    = issue_live && we_q;
        mem_addr  = addr_q;
        mem_din   = wdata_q;
        c0_rvalid = rvalid0_q;
        c1_rvalid = rvalid1_q;
        c0_rdata  = rdata0_q;
        c1_rdata  = rdata1_q;
    end

endmodule
